// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational 16-bit ALU between two requesters.
// A request is granted in IDLE and its operands are latched into a one-deep
// issue register. The ALU is driven for one cycle (EXEC). The result is then
// returned on the granted requester's valid/ready response channel (RESP).
// Each requester owns an {N,Z,V} flag register. The flag register is updated
// through a per-op mask, not by passing the ALU flags straight through.
// Optional feature macro: ALU_ARB_RR_EN selects round-robin tie-breaking.
// When the macro is undefined, requester 0 has fixed priority.
// Opcode values mirror the ALU_* / major-opcode constants of defines.v.
module alu_arbiter (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic [3:0]  req0_op,
   input  logic [15:0] req0_src0,
   input  logic [15:0] req0_src1,
   input  logic [3:0]  req0_shamt,
   input  logic [15:0] req0_instr,
   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic [3:0]  req1_op,
   input  logic [15:0] req1_src0,
   input  logic [15:0] req1_src1,
   input  logic [3:0]  req1_shamt,
   input  logic [15:0] req1_instr,
   output logic [15:0] alu_src0,
   output logic [15:0] alu_src1,
   output logic [3:0]  alu_op,
   output logic [3:0]  alu_shamt,
   output logic [15:0] alu_instr,
   output logic [2:0]  alu_flags_in,
   input  logic [15:0] alu_dst,
   input  logic        alu_n,
   input  logic        alu_z,
   input  logic        alu_v,
   output logic        rsp0_valid,
   input  logic        rsp0_ready,
   output logic [15:0] rsp0_data,
   output logic        rsp1_valid,
   input  logic        rsp1_ready,
   output logic [15:0] rsp1_data,
   output logic [2:0]  flags0,
   output logic [2:0]  flags1
);

   localparam logic [3:0] ALU_ADD = 4'h0;
   localparam logic [3:0] ALU_SUB = 4'h1;
   localparam logic [3:0] ALU_AND = 4'h2;
   localparam logic [3:0] ALU_NOR = 4'h3;
   localparam logic [3:0] ALU_SLL = 4'h4;
   localparam logic [3:0] ALU_SRL = 4'h5;
   localparam logic [3:0] ALU_SRA = 4'h6;
   localparam logic [3:0] ALU_NOP = 4'h8;

   localparam logic [3:0] LW  = 4'h8;
   localparam logic [3:0] SW  = 4'h9;
   localparam logic [3:0] LLB = 4'hA;
   localparam logic [3:0] B   = 4'hC;
   localparam logic [3:0] JAL = 4'hD;
   localparam logic [3:0] JR  = 4'hE;

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t      stateReg, stateNext;
   logic        accept;
   logic        grantPick;
   logic        tiePick;
   logic        rspReadySel;
   logic        grantReg;
   logic [3:0]  opReg, shamtReg;
   logic [15:0] src0Reg, src1Reg, instrReg, resultReg;
   logic [2:0]  flagsUpd;
   logic        addrAdd;

`ifdef ALU_ARB_RR_EN
   logic        lastGrantReg;

   // Tie goes to the requester that was not granted last time.
   always_comb begin
      tiePick = ~lastGrantReg;
   end

   // Remember the last grant. The reset value makes requester 0 win the first tie.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         lastGrantReg <= 1'b1;
      else if (accept)
         lastGrantReg <= grantPick;
   end
`else
   // Fixed priority: requester 0 always wins a tie.
   always_comb begin
      tiePick = 1'b0;
   end
`endif

   // Grant selection. If only one requester is valid, it wins.
   always_comb begin
      grantPick = (req0_valid & req1_valid) ? tiePick : req1_valid;
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         stateReg <= IDLE;
      else
         stateReg <= stateNext;
   end

   // Next-state logic and accept pulses.
   always_comb begin
      stateNext   = stateReg;
      accept      = 1'b0;
      rspReadySel = grantReg ? rsp1_ready : rsp0_ready;
      case (stateReg)
         IDLE: begin
            if (req0_valid | req1_valid) begin
               accept    = 1'b1;
               stateNext = EXEC;
            end
         end
         EXEC: stateNext = RESP;
         RESP: begin
            if (rspReadySel)
               stateNext = IDLE;
         end
         default: stateNext = IDLE;
      endcase
      req0_ready = accept & ~grantPick;
      req1_ready = accept & grantPick;
   end

   // Issue register: sampled only on the accept cycle. It holds its value
   // afterwards, so the ALU inputs keep the last issued operation while in IDLE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         grantReg <= 1'b0;
         opReg    <= '0;
         shamtReg <= '0;
         src0Reg  <= '0;
         src1Reg  <= '0;
         instrReg <= '0;
      end else if (accept) begin
         grantReg <= grantPick;
         opReg    <= grantPick ? req1_op    : req0_op;
         shamtReg <= grantPick ? req1_shamt : req0_shamt;
         src0Reg  <= grantPick ? req1_src0  : req0_src0;
         src1Reg  <= grantPick ? req1_src1  : req0_src1;
         instrReg <= grantPick ? req1_instr : req0_instr;
      end
   end

   // Result capture at the end of EXEC. The ALU output is ignored for NOP.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         resultReg <= '0;
      else if (stateReg == EXEC)
         resultReg <= (opReg == ALU_NOP) ? 16'h0000 : alu_dst;
   end

   // Flag update mask. An ADD used for address/link computation leaves the flags alone.
   always_comb begin
      addrAdd  = (instrReg[15:12] == JAL) || (instrReg[15:12] == JR) ||
                 (instrReg[15:12] == LLB) || (instrReg[15:12] == LW) ||
                 (instrReg[15:12] == SW)  || (instrReg[15:12] == B);
      flagsUpd = alu_flags_in;
      case (opReg)
         ALU_ADD: begin
            if (!addrAdd)
               flagsUpd = {alu_n, alu_z, alu_v};
         end
         ALU_SUB: flagsUpd = {alu_n, alu_z, alu_v};
         ALU_AND, ALU_NOR, ALU_SLL, ALU_SRL, ALU_SRA: flagsUpd[1] = alu_z;
         default: flagsUpd = alu_flags_in;
      endcase
   end

   // Per-requester flag registers. Only the granted one is written, and only in EXEC.
   for (genvar gi = 0; gi < 2; gi++) begin : gFlag
      logic [2:0] flagsReg;
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n)
            flagsReg <= 3'b000;
         else if ((stateReg == EXEC) && (grantReg == gi[0]))
            flagsReg <= flagsUpd;
      end
   end

   // ALU drive, response channels and flag outputs.
   always_comb begin
      alu_src0     = src0Reg;
      alu_src1     = src1Reg;
      alu_op       = opReg;
      alu_shamt    = shamtReg;
      alu_instr    = instrReg;
      alu_flags_in = grantReg ? gFlag[1].flagsReg : gFlag[0].flagsReg;
      rsp0_valid   = (stateReg == RESP) & ~grantReg;
      rsp1_valid   = (stateReg == RESP) & grantReg;
      rsp0_data    = rsp0_valid ? resultReg : 16'h0000;
      rsp1_data    = rsp1_valid ? resultReg : 16'h0000;
      flags0       = gFlag[0].flagsReg;
      flags1       = gFlag[1].flagsReg;
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed testbench for alu_arbiter. A small behavioural saturating ALU closes
// the loop around the ALU-side ports.
module tb_alu_arbiter;

   localparam logic [3:0] ALU_ADD = 4'h0;
   localparam logic [3:0] ALU_SUB = 4'h1;
   localparam logic [3:0] ALU_AND = 4'h2;
   localparam logic [3:0] ALU_SLL = 4'h4;
   localparam logic [3:0] ALU_SRA = 4'h6;
   localparam logic [3:0] ALU_LHB = 4'h7;
   localparam logic [3:0] ALU_NOP = 4'h8;
   localparam logic [3:0] ALU_UND = 4'hF;

`ifdef ALU_ARB_RR_EN
   localparam bit RR_MODE = 1'b1;
`else
   localparam bit RR_MODE = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req0_valid, req0_ready, req1_valid, req1_ready;
   logic [3:0]  req0_op, req0_shamt, req1_op, req1_shamt;
   logic [15:0] req0_src0, req0_src1, req0_instr, req1_src0, req1_src1, req1_instr;
   logic [15:0] alu_src0, alu_src1, alu_instr, alu_dst;
   logic [3:0]  alu_op, alu_shamt;
   logic [2:0]  alu_flags_in;
   logic        alu_n, alu_z, alu_v;
   logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
   logic [15:0] rsp0_data, rsp1_data;
   logic [2:0]  flags0, flags1;

   int compared = 0;
   int mismatched = 0;

   always #5 clk = ~clk;

   alu_arbiter dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
      .req0_src0(req0_src0), .req0_src1(req0_src1), .req0_shamt(req0_shamt),
      .req0_instr(req0_instr),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
      .req1_src0(req1_src0), .req1_src1(req1_src1), .req1_shamt(req1_shamt),
      .req1_instr(req1_instr),
      .alu_src0(alu_src0), .alu_src1(alu_src1), .alu_op(alu_op),
      .alu_shamt(alu_shamt), .alu_instr(alu_instr), .alu_flags_in(alu_flags_in),
      .alu_dst(alu_dst), .alu_n(alu_n), .alu_z(alu_z), .alu_v(alu_v),
      .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data),
      .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data),
      .flags0(flags0), .flags1(flags1)
   );

   // Behavioural saturating ALU. NOP returns garbage on purpose, and undefined
   // ops raise every flag, so the arbiter's masking is visible.
   always_comb begin
      logic [15:0] s;
      s     = 16'h0000;
      alu_v = 1'b0;
      case (alu_op)
         ALU_ADD: begin
            s     = alu_src0 + alu_src1;
            alu_v = (alu_src0[15] == alu_src1[15]) && (s[15] != alu_src0[15]);
            if (alu_v) s = alu_src0[15] ? 16'h8000 : 16'h7FFF;
         end
         ALU_SUB: begin
            s     = alu_src0 - alu_src1;
            alu_v = (alu_src0[15] != alu_src1[15]) && (s[15] != alu_src0[15]);
            if (alu_v) s = alu_src0[15] ? 16'h8000 : 16'h7FFF;
         end
         ALU_AND: s = alu_src0 & alu_src1;
         4'h3:    s = ~(alu_src0 | alu_src1);
         ALU_SLL: s = alu_src0 << alu_shamt;
         4'h5:    s = alu_src0 >> alu_shamt;
         ALU_SRA: s = $signed(alu_src0) >>> alu_shamt;
         ALU_LHB: s = {alu_src1[7:0], alu_src0[7:0]};
         ALU_NOP: s = 16'hDEAD;
         default: s = 16'h1234;
      endcase
      alu_dst = s;
      alu_n   = s[15];
      alu_z   = (s == 16'h0000);
      if (alu_op == ALU_UND) begin
         alu_n = 1'b1;
         alu_z = 1'b1;
         alu_v = 1'b1;
      end
   end

   task automatic applyReset();
      rst_n = 1'b0;
      req0_valid = 0; req0_op = 0; req0_src0 = 0; req0_src1 = 0; req0_shamt = 0; req0_instr = 0;
      req1_valid = 0; req1_op = 0; req1_src0 = 0; req1_src1 = 0; req1_shamt = 0; req1_instr = 0;
      rsp0_ready = 1'b1; rsp1_ready = 1'b1;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic driveReq(input int k, input logic [3:0] op, input logic [15:0] s0,
                           input logic [15:0] s1, input logic [3:0] sh, input logic [15:0] ins);
      if (k == 0) begin
         req0_valid = 1; req0_op = op; req0_src0 = s0; req0_src1 = s1; req0_shamt = sh; req0_instr = ins;
      end else begin
         req1_valid = 1; req1_op = op; req1_src0 = s0; req1_src1 = s1; req1_shamt = sh; req1_instr = ins;
      end
   endtask

   // Issue one op on requester k and collect its response (response ready assumed high).
   // Returns at posedge+1 after retirement.
   task automatic doOp(input int k, input logic [3:0] op, input logic [15:0] s0,
                       input logic [15:0] s1, input logic [3:0] sh, input logic [15:0] ins,
                       output logic [15:0] data, output int lat, output bit tmo);
      int n;
      tmo = 0; data = 16'h0000; lat = 0; n = 0;
      @(negedge clk);
      driveReq(k, op, s0, s1, sh, ins);
      #1;
      while ((((k == 0) ? req0_ready : req1_ready) !== 1'b1) && (n < 20)) begin
         @(negedge clk); #1; n++;
      end
      if (n >= 20) begin
         tmo = 1; req0_valid = 0; req1_valid = 0;
         return;
      end
      @(posedge clk);
      @(negedge clk);
      if (k == 0) req0_valid = 0; else req1_valid = 0;
      lat = 1;
      #1;
      while ((((k == 0) ? rsp0_valid : rsp1_valid) !== 1'b1) && (lat < 20)) begin
         @(negedge clk); #1; lat++;
      end
      if (lat >= 20) begin
         tmo = 1;
         return;
      end
      data = (k == 0) ? rsp0_data : rsp1_data;
      $display("op: req%0d op=%h src0=%h src1=%h data=%h lat=%0d", k, op, s0, s1, data, lat);
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      applyReset();
      #1;
      compared++;
      if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid} !== 4'b0000) begin
         mismatched++;
         $display("FAIL reset_handshake got %b required 0000", {req0_ready, req1_ready, rsp0_valid, rsp1_valid});
      end
      compared++;
      if ({rsp0_data, rsp1_data, flags0, flags1} !== 38'h0) begin
         mismatched++;
         $display("FAIL reset_data_flags got %h %h %b %b required zero", rsp0_data, rsp1_data, flags0, flags1);
      end
      compared++;
      if ({alu_src0, alu_src1, alu_op, alu_shamt, alu_instr, alu_flags_in} !== 59'h0) begin
         mismatched++;
         $display("FAIL reset_alu_outputs got %h %h %h %h %h required zero", alu_src0, alu_src1, alu_op, alu_shamt, alu_instr);
      end
      $display("reset: checked idle state");
   endtask

   task automatic test_single_add();
      logic [15:0] d; int lat; bit tmo;
      doOp(0, ALU_ADD, 16'h7000, 16'h2000, 4'h0, 16'h0000, d, lat, tmo);
      compared++;
      if (tmo || d !== 16'h7FFF) begin
         mismatched++;
         $display("FAIL add_data got %h required 7fff (timeout=%0d)", d, tmo);
      end
      compared++;
      if (lat !== 2) begin
         mismatched++;
         $display("FAIL add_latency got %0d required 2", lat);
      end
      compared++;
      if ({flags0, flags1} !== 6'b001_000) begin
         mismatched++;
         $display("FAIL add_flags got %b/%b required 001/000", flags0, flags1);
      end
      compared++;
      if ({alu_src0, alu_src1} !== {16'h7000, 16'h2000}) begin
         mismatched++;
         $display("FAIL idle_alu_hold got %h %h required 7000 2000", alu_src0, alu_src1);
      end
   endtask

   task automatic test_masking();
      logic [3:0]  ops [6] = '{ALU_SUB, ALU_AND, ALU_SUB, ALU_AND, ALU_ADD, ALU_ADD};
      logic [15:0] a   [6] = '{16'h8000, 16'h00F0, 16'h0005, 16'h00F0, 16'h8000, 16'h8000};
      logic [15:0] b   [6] = '{16'h0001, 16'h0F00, 16'h0005, 16'h0F00, 16'h8000, 16'h8000};
      logic [15:0] ins [6] = '{16'h1000, 16'h2000, 16'h1000, 16'h2000, 16'h8123, 16'h0000};
      logic [15:0] ed  [6] = '{16'h8000, 16'h0000, 16'h0000, 16'h0000, 16'h8000, 16'h8000};
      logic [2:0]  ef  [6] = '{3'b101, 3'b111, 3'b010, 3'b010, 3'b010, 3'b101};
      logic [15:0] d; int lat; bit tmo;
      for (int i = 0; i < 6; i++) begin
         doOp(1, ops[i], a[i], b[i], 4'h0, ins[i], d, lat, tmo);
         compared++;
         if (tmo || d !== ed[i] || flags1 !== ef[i]) begin
            mismatched++;
            $display("FAIL mask_step%0d got data=%h flags1=%b required data=%h flags1=%b (timeout=%0d)",
                     i, d, flags1, ed[i], ef[i], tmo);
         end
      end
      compared++;
      if (flags0 !== 3'b001) begin
         mismatched++;
         $display("FAIL mask_other_flags got %b required 001", flags0);
      end
   endtask

   task automatic test_nop_shifts();
      logic [3:0]  ops [5] = '{ALU_NOP, ALU_SLL, ALU_SRA, ALU_LHB, ALU_UND};
      logic [15:0] a   [5] = '{16'h5555, 16'h8000, 16'h8000, 16'h1234, 16'h0001};
      logic [15:0] b   [5] = '{16'h1111, 16'h0000, 16'h0000, 16'h00AB, 16'h0002};
      logic [3:0]  sh  [5] = '{4'h0, 4'h1, 4'h4, 4'h0, 4'h0};
      logic [15:0] ed  [5] = '{16'h0000, 16'h0000, 16'hF800, 16'hAB34, 16'h1234};
      logic [2:0]  ef  [5] = '{3'b001, 3'b011, 3'b001, 3'b001, 3'b001};
      logic [15:0] d; int lat; bit tmo;
      for (int i = 0; i < 5; i++) begin
         doOp(0, ops[i], a[i], b[i], sh[i], 16'h0000, d, lat, tmo);
         compared++;
         if (tmo || d !== ed[i] || flags0 !== ef[i]) begin
            mismatched++;
            $display("FAIL nopshift_step%0d got data=%h flags0=%b required data=%h flags0=%b (timeout=%0d)",
                     i, d, flags0, ed[i], ef[i], tmo);
         end
      end
   endtask

   task automatic test_contention();
      int grants [4];
      int cyc [4];
      int ng = 0;
      int both = 0;
      applyReset();
      @(negedge clk);
      driveReq(0, ALU_ADD, 16'h0001, 16'h0001, 4'h0, 16'h0000);
      driveReq(1, ALU_ADD, 16'h0002, 16'h0002, 4'h0, 16'h0000);
      for (int c = 0; c < 40 && ng < 4; c++) begin
         #1;
         if (req0_ready && req1_ready) both++;
         if (req0_ready || req1_ready) begin
            grants[ng] = req1_ready ? 1 : 0;
            cyc[ng] = c;
            $display("contention: grant %0d to req%0d at cycle %0d", ng, grants[ng], c);
            ng++;
         end
         @(negedge clk);
      end
      req0_valid = 0; req1_valid = 0;
      repeat (4) @(negedge clk);
      compared++;
      if (ng !== 4 || both !== 0) begin
         mismatched++;
         $display("FAIL contention_count got grants=%0d double=%0d required 4 and 0", ng, both);
      end
      for (int i = 0; i < ng; i++) begin
         compared++;
         if (grants[i] !== (RR_MODE ? (i % 2) : 0)) begin
            mismatched++;
            $display("FAIL contention_grant%0d got %0d required %0d", i, grants[i], RR_MODE ? (i % 2) : 0);
         end
      end
      compared++;
      if (ng == 4 && (cyc[1] - cyc[0] !== 3 || cyc[3] - cyc[2] !== 3)) begin
         mismatched++;
         $display("FAIL contention_interval got %0d %0d required 3", cyc[1] - cyc[0], cyc[3] - cyc[2]);
      end
   endtask

   task automatic test_back_to_back();
      int n = 0;
      int lat;
      rsp0_ready = 1'b0;
      @(negedge clk);
      driveReq(0, ALU_ADD, 16'h0001, 16'h0002, 4'h0, 16'h0000);
      #1;
      while (req0_ready !== 1'b1 && n < 20) begin @(negedge clk); #1; n++; end
      @(posedge clk);
      @(negedge clk);
      req0_valid = 0;
      driveReq(1, ALU_ADD, 16'h0004, 16'h0005, 4'h0, 16'h0000);
      n = 0;
      #1;
      while (rsp0_valid !== 1'b1 && n < 20) begin @(negedge clk); #1; n++; end
      compared++;
      if (n >= 20) begin
         mismatched++;
         $display("FAIL bp_rsp_arrive got valid=%b required 1", rsp0_valid);
      end
      for (int i = 0; i < 5; i++) begin
         compared++;
         if (rsp0_valid !== 1'b1 || rsp0_data !== 16'h0003 || req1_ready !== 1'b0) begin
            mismatched++;
            $display("FAIL bp_stall%0d got valid=%b data=%h req1_ready=%b required 1 0003 0",
                     i, rsp0_valid, rsp0_data, req1_ready);
         end
         @(negedge clk); #1;
      end
      rsp0_ready = 1'b1;
      #1;
      compared++;
      if (req1_ready !== 1'b0) begin
         mismatched++;
         $display("FAIL bp_retire_cycle got req1_ready=%b required 0", req1_ready);
      end
      @(negedge clk); #1;
      compared++;
      if (rsp0_valid !== 1'b0 || req1_ready !== 1'b1) begin
         mismatched++;
         $display("FAIL bp_accept_after got rsp0_valid=%b req1_ready=%b required 0 1", rsp0_valid, req1_ready);
      end
      @(posedge clk);
      @(negedge clk);
      req1_valid = 0;
      lat = 1;
      #1;
      while (rsp1_valid !== 1'b1 && lat < 20) begin @(negedge clk); #1; lat++; end
      compared++;
      if (lat !== 2 || rsp1_data !== 16'h0009) begin
         mismatched++;
         $display("FAIL bp_req1_result got data=%h lat=%0d required 0009 2", rsp1_data, lat);
      end
      $display("backpressure: req1 data=%h lat=%0d", rsp1_data, lat);
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid();
      logic [15:0] d; int lat; bit tmo;
      int n = 0;
      int sawValid = 0;
      doOp(1, ALU_SUB, 16'h8000, 16'h0001, 4'h0, 16'h1000, d, lat, tmo);
      @(negedge clk);
      driveReq(0, ALU_ADD, 16'h7000, 16'h2000, 4'h0, 16'h0000);
      #1;
      while (req0_ready !== 1'b1 && n < 20) begin @(negedge clk); #1; n++; end
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      req0_valid = 0;
      #1;
      compared++;
      if ({rsp0_valid, rsp1_valid, flags0, flags1} !== 8'h00) begin
         mismatched++;
         $display("FAIL midreset_clear got valid=%b%b flags=%b/%b required 00 000/000",
                  rsp0_valid, rsp1_valid, flags0, flags1);
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         if (rsp0_valid || rsp1_valid) sawValid++;
         @(negedge clk);
      end
      compared++;
      if (sawValid !== 0 || {flags0, flags1} !== 6'b0) begin
         mismatched++;
         $display("FAIL midreset_dropped got valid_cycles=%0d flags=%b/%b required 0 000/000",
                  sawValid, flags0, flags1);
      end
      doOp(0, ALU_ADD, 16'h0001, 16'h0001, 4'h0, 16'h0000, d, lat, tmo);
      compared++;
      if (tmo || d !== 16'h0002 || lat !== 2 || flags0 !== 3'b000) begin
         mismatched++;
         $display("FAIL midreset_recover got data=%h lat=%0d flags0=%b required 0002 2 000 (timeout=%0d)",
                  d, lat, flags0, tmo);
      end
   endtask

   initial begin
      test_reset();
      test_single_add();
      test_masking();
      test_nop_shifts();
      test_contention();
      test_back_to_back();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   // Hard bound so the run always ends.
   initial begin
      #200000;
      $display("FAIL global_timeout got running required finished");
      $fatal(1, "timeout");
   end

endmodule
